// File: rtl/nasti_hp_pkg.sv
// rtl/nasti_hp_pkg.sv - shared widths, response codes and AR/AW payload for the HP adapter
package nasti_hp_pkg;

  localparam int ADDR_W = 32;
  localparam int ID_W   = 6;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;
  localparam int DATA_W = 64;
  localparam int RESP_W = 2;

  typedef enum logic [RESP_W-1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
  } ax_t;

  localparam int AX_W = $bits(ax_t);

  // Saturating up/down counter step: simultaneous inc and dec cancel, never wraps.
  function automatic logic [7:0] cnt_next(input logic [7:0] cnt, input logic inc,
                                          input logic dec, input logic [7:0] max);
    if (inc && !dec) return (cnt == max) ? cnt : cnt + 8'd1;
    if (dec && !inc) return (cnt == 8'd0) ? cnt : cnt - 8'd1;
    return cnt;
  endfunction

endpackage

// File: rtl/nasti_hp_adapter_if.sv
// rtl/nasti_hp_adapter_if.sv - five-channel NASTI bus bundle with master/slave views
interface nasti_hp_if;
  import nasti_hp_pkg::*;

  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [ID_W-1:0]   ar_id;
  logic [LEN_W-1:0]  ar_len;
  logic [SIZE_W-1:0] ar_size;

  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [ID_W-1:0]   aw_id;
  logic [LEN_W-1:0]  aw_len;
  logic [SIZE_W-1:0] aw_size;

  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic              w_last;

  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [ID_W-1:0]   r_id;
  logic [RESP_W-1:0] r_resp;
  logic              r_last;

  logic              b_valid;
  logic              b_ready;
  logic [ID_W-1:0]   b_id;
  logic [RESP_W-1:0] b_resp;

  modport master (
    output ar_valid, ar_addr, ar_id, ar_len, ar_size, input ar_ready,
    output aw_valid, aw_addr, aw_id, aw_len, aw_size, input aw_ready,
    output w_valid, w_data, w_last, input w_ready,
    input  r_valid, r_data, r_id, r_resp, r_last, output r_ready,
    input  b_valid, b_id, b_resp, output b_ready
  );

  modport slave (
    input  ar_valid, ar_addr, ar_id, ar_len, ar_size, output ar_ready,
    input  aw_valid, aw_addr, aw_id, aw_len, aw_size, output aw_ready,
    input  w_valid, w_data, w_last, output w_ready,
    output r_valid, r_data, r_id, r_resp, r_last, input r_ready,
    output b_valid, b_id, b_resp, input b_ready
  );

endinterface

// File: rtl/nasti_skid_buf.sv
// rtl/nasti_skid_buf.sv - 2-entry in-order skid buffer, full throughput, ready = not full
module nasti_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_valid && o_ready;
  assign w_pop   = o_valid && i_ready;

  // Payload storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/nasti_hp_adapter.sv
// rtl/nasti_hp_adapter.sv - NastiShim to Zynq S_AXI_HP bridge with remap, limits and error capture
module nasti_hp_adapter
  import nasti_hp_pkg::*;
#(
  parameter int                           REMAP_BITS = 28,
  parameter logic [ADDR_W-REMAP_BITS-1:0] ADDR_HI    = 'h1,
  parameter int                           MAX_RD     = 8,
  parameter int                           MAX_WR     = 8
) (
  input  logic              clk,
  input  logic              reset,
  nasti_hp_if.slave         up,
  nasti_hp_if.master        hp,
  output logic [7:0]        rd_outstanding,
  output logic [7:0]        wr_outstanding,
  output logic              err_valid,
  output logic              err_is_write,
  output logic [ID_W-1:0]   err_id,
  output logic [RESP_W-1:0] err_resp,
  input  logic              err_clear
);

  localparam logic [7:0] MAX_RD_C = 8'(MAX_RD);
  localparam logic [7:0] MAX_WR_C = 8'(MAX_WR);

  logic [7:0]        r_rd_cnt;
  logic [7:0]        r_wr_cnt;
  logic [7:0]        r_w_credit;
  logic              r_err_valid;
  logic              r_err_is_write;
  logic [ID_W-1:0]   r_err_id;
  logic [RESP_W-1:0] r_err_resp;

  ax_t  w_ar_in, w_ar_out, w_aw_in, w_aw_out;
  logic w_ar_sk_valid, w_aw_sk_valid;
  logic w_rd_room, w_wr_room, w_credit_ok;
  logic w_ar_fire, w_aw_fire, w_w_last_fire, w_r_fire, w_r_last_fire, w_b_fire;
  logic w_rd_uf, w_wr_uf;
  logic w_new_err, w_new_is_write;
  logic [ID_W-1:0]   w_new_id;
  logic [RESP_W-1:0] w_new_resp;

  // The top address bits are replaced by the DDR window, so the incoming ones are dropped.
  logic w_unused_hi;
  assign w_unused_hi = ^{up.ar_addr[ADDR_W-1:REMAP_BITS], up.aw_addr[ADDR_W-1:REMAP_BITS]};

  assign w_ar_in = '{addr: {ADDR_HI, up.ar_addr[REMAP_BITS-1:0]}, id: up.ar_id,
                     len: up.ar_len, size: up.ar_size};
  assign w_aw_in = '{addr: {ADDR_HI, up.aw_addr[REMAP_BITS-1:0]}, id: up.aw_id,
                     len: up.aw_len, size: up.aw_size};

  assign w_rd_room   = (r_rd_cnt < MAX_RD_C);
  assign w_wr_room   = (r_wr_cnt < MAX_WR_C);
  assign w_credit_ok = (r_w_credit != 8'd0);

  nasti_skid_buf #(.W(AX_W)) u_ar_skid (
    .clk(clk), .rst(reset),
    .i_valid(up.ar_valid), .o_ready(up.ar_ready), .i_data(w_ar_in),
    .o_valid(w_ar_sk_valid), .i_ready(hp.ar_ready && w_rd_room), .o_data(w_ar_out)
  );

  nasti_skid_buf #(.W(AX_W)) u_aw_skid (
    .clk(clk), .rst(reset),
    .i_valid(up.aw_valid), .o_ready(up.aw_ready), .i_data(w_aw_in),
    .o_valid(w_aw_sk_valid), .i_ready(hp.aw_ready && w_wr_room), .o_data(w_aw_out)
  );

  assign hp.ar_valid = w_ar_sk_valid && w_rd_room;
  assign hp.ar_addr  = w_ar_out.addr;
  assign hp.ar_id    = w_ar_out.id;
  assign hp.ar_len   = w_ar_out.len;
  assign hp.ar_size  = w_ar_out.size;

  assign hp.aw_valid = w_aw_sk_valid && w_wr_room;
  assign hp.aw_addr  = w_aw_out.addr;
  assign hp.aw_id    = w_aw_out.id;
  assign hp.aw_len   = w_aw_out.len;
  assign hp.aw_size  = w_aw_out.size;

  // W beats are gated until their AW has gone out on the HP side.
  assign hp.w_valid = up.w_valid && w_credit_ok;
  assign up.w_ready = hp.w_ready && w_credit_ok;
  assign hp.w_data  = up.w_data;
  assign hp.w_last  = up.w_last;

  assign up.r_valid = hp.r_valid;
  assign up.r_data  = hp.r_data;
  assign up.r_id    = hp.r_id;
  assign up.r_resp  = hp.r_resp;
  assign up.r_last  = hp.r_last;
  assign hp.r_ready = up.r_ready;

  assign up.b_valid = hp.b_valid;
  assign up.b_id    = hp.b_id;
  assign up.b_resp  = hp.b_resp;
  assign hp.b_ready = up.b_ready;

  assign w_ar_fire     = hp.ar_valid && hp.ar_ready;
  assign w_aw_fire     = hp.aw_valid && hp.aw_ready;
  assign w_w_last_fire = hp.w_valid && hp.w_ready && hp.w_last;
  assign w_r_fire      = hp.r_valid && hp.r_ready;
  assign w_r_last_fire = w_r_fire && hp.r_last;
  assign w_b_fire      = hp.b_valid && hp.b_ready;

  // A W-last can never arrive at zero credit because hp.w_valid is gated on credit.
  assign w_rd_uf = w_r_last_fire && (r_rd_cnt == 8'd0);
  assign w_wr_uf = w_b_fire && (r_wr_cnt == 8'd0);

  // Outstanding-burst and W-credit counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_cnt   <= 8'd0;
      r_wr_cnt   <= 8'd0;
      r_w_credit <= 8'd0;
    end else begin
      r_rd_cnt   <= cnt_next(r_rd_cnt, w_ar_fire, w_r_last_fire, MAX_RD_C);
      r_wr_cnt   <= cnt_next(r_wr_cnt, w_aw_fire, w_b_fire, MAX_WR_C);
      r_w_credit <= cnt_next(r_w_credit, w_aw_fire, w_w_last_fire, MAX_WR_C);
    end
  end

  // Pick this cycle's error candidate; B has priority over R, underflow reports DECERR.
  always_comb begin
    w_new_err      = 1'b0;
    w_new_is_write = 1'b0;
    w_new_id       = '0;
    w_new_resp     = '0;
    if (w_b_fire && (w_wr_uf || hp.b_resp != RESP_OKAY)) begin
      w_new_err      = 1'b1;
      w_new_is_write = 1'b1;
      w_new_id       = hp.b_id;
      w_new_resp     = w_wr_uf ? RESP_DECERR : hp.b_resp;
    end else if (w_r_fire && (w_rd_uf || hp.r_resp != RESP_OKAY)) begin
      w_new_err      = 1'b1;
      w_new_id       = hp.r_id;
      w_new_resp     = w_rd_uf ? RESP_DECERR : hp.r_resp;
    end
  end

  // Sticky first-error record; a new error beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_valid    <= 1'b0;
      r_err_is_write <= 1'b0;
      r_err_id       <= '0;
      r_err_resp     <= '0;
    end else if (w_new_err && (!r_err_valid || err_clear)) begin
      r_err_valid    <= 1'b1;
      r_err_is_write <= w_new_is_write;
      r_err_id       <= w_new_id;
      r_err_resp     <= w_new_resp;
    end else if (err_clear) begin
      r_err_valid    <= 1'b0;
      r_err_is_write <= 1'b0;
      r_err_id       <= '0;
      r_err_resp     <= '0;
    end
  end

  assign rd_outstanding = r_rd_cnt;
  assign wr_outstanding = r_wr_cnt;
  assign err_valid      = r_err_valid;
  assign err_is_write   = r_err_is_write;
  assign err_id         = r_err_id;
  assign err_resp       = r_err_resp;

endmodule

// File: tb/tb_nasti_hp_adapter.sv
// tb/tb_nasti_hp_adapter.sv - scoreboard bench for nasti_hp_adapter
module tb_nasti_hp_adapter;
  import nasti_hp_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       err_clear = 1'b0;
  logic [7:0] rd_outstanding, wr_outstanding;
  logic       err_valid, err_is_write;
  logic [5:0] err_id;
  logic [1:0] err_resp;

  nasti_hp_if up_if();
  nasti_hp_if hp_if();

  nasti_hp_adapter #(.REMAP_BITS(28), .ADDR_HI(4'h1), .MAX_RD(2), .MAX_WR(8)) dut (
    .clk(clk), .reset(reset), .up(up_if), .hp(hp_if),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .err_valid(err_valid), .err_is_write(err_is_write), .err_id(err_id),
    .err_resp(err_resp), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_ar_hs = 0;
  int n_aw_hs = 0;
  ax_t exp_ar_q[$];
  ax_t exp_aw_q[$];
  logic [63:0] exp_d_q[$];

  function automatic ax_t mk_hp(input ax_t a);
    ax_t r;
    r = a;
    r.addr[31:28] = 4'h1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive_ar(input ax_t a);
    up_if.ar_valid = 1'b1;
    up_if.ar_addr = a.addr; up_if.ar_id = a.id; up_if.ar_len = a.len; up_if.ar_size = a.size;
    exp_ar_q.push_back(mk_hp(a));
  endtask

  task automatic drive_aw(input ax_t a);
    up_if.aw_valid = 1'b1;
    up_if.aw_addr = a.addr; up_if.aw_id = a.id; up_if.aw_len = a.len; up_if.aw_size = a.size;
    exp_aw_q.push_back(mk_hp(a));
  endtask

  // Scoreboard: every HP AR handshake must match the next expected remapped request.
  always @(negedge clk) begin : mon_ar
    ax_t got, e;
    if (!reset && hp_if.ar_valid && hp_if.ar_ready) begin
      got = '{addr: hp_if.ar_addr, id: hp_if.ar_id, len: hp_if.ar_len, size: hp_if.ar_size};
      n_ar_hs++;
      checks++;
      if (exp_ar_q.size() == 0) begin
        errors++; $display("FAIL hp_ar_unexpected got=%h req=none", got);
      end else begin
        e = exp_ar_q.pop_front();
        if (got !== e) begin errors++; $display("FAIL hp_ar_payload got=%h req=%h", got, e); end
      end
    end
  end

  always @(negedge clk) begin : mon_aw
    ax_t got, e;
    if (!reset && hp_if.aw_valid && hp_if.aw_ready) begin
      got = '{addr: hp_if.aw_addr, id: hp_if.aw_id, len: hp_if.aw_len, size: hp_if.aw_size};
      n_aw_hs++;
      checks++;
      if (exp_aw_q.size() == 0) begin
        errors++; $display("FAIL hp_aw_unexpected got=%h req=none", got);
      end else begin
        e = exp_aw_q.pop_front();
        if (got !== e) begin errors++; $display("FAIL hp_aw_payload got=%h req=%h", got, e); end
      end
    end
  end

  task automatic test_reset();
    repeat (2) step();
    reset = 1'b0;
    smp();
    checks++; if (up_if.ar_ready !== 1'b1) begin errors++; $display("FAIL rst_ar_ready got=%b req=1", up_if.ar_ready); end
    checks++; if (up_if.aw_ready !== 1'b1) begin errors++; $display("FAIL rst_aw_ready got=%b req=1", up_if.aw_ready); end
    checks++; if (hp_if.ar_valid !== 1'b0) begin errors++; $display("FAIL rst_ar_valid got=%b req=0", hp_if.ar_valid); end
    checks++; if (hp_if.aw_valid !== 1'b0) begin errors++; $display("FAIL rst_aw_valid got=%b req=0", hp_if.aw_valid); end
    checks++; if (rd_outstanding !== 8'd0) begin errors++; $display("FAIL rst_rd_cnt got=%0d req=0", rd_outstanding); end
    checks++; if (wr_outstanding !== 8'd0) begin errors++; $display("FAIL rst_wr_cnt got=%0d req=0", wr_outstanding); end
    checks++; if ({err_valid, err_is_write, err_id, err_resp} !== 10'd0) begin errors++; $display("FAIL rst_err got=%b req=0", {err_valid, err_is_write, err_id, err_resp}); end
    step();
  endtask

  task automatic test_single_read();
    int base;
    base = n_ar_hs;
    drive_ar('{addr: 32'h0000_1040, id: 6'd3, len: 8'd3, size: 3'd3});
    smp();
    checks++; if (hp_if.ar_valid !== 1'b0) begin errors++; $display("FAIL rd1_latency got=%b req=0", hp_if.ar_valid); end
    step();
    up_if.ar_valid = 1'b0;
    smp();
    checks++; if (hp_if.ar_valid !== 1'b1) begin errors++; $display("FAIL rd1_hp_valid got=%b req=1", hp_if.ar_valid); end
    checks++; if (hp_if.ar_addr !== 32'h1000_1040) begin errors++; $display("FAIL rd1_hp_addr got=%h req=10001040", hp_if.ar_addr); end
    step();
    smp();
    checks++; if (rd_outstanding !== 8'd1) begin errors++; $display("FAIL rd1_cnt_up got=%0d req=1", rd_outstanding); end
    checks++; if (n_ar_hs - base !== 1) begin errors++; $display("FAIL rd1_hs got=%0d req=1", n_ar_hs - base); end
    step();
    for (int i = 0; i < 4; i++) begin
      hp_if.r_valid = 1'b1; hp_if.r_id = 6'd3; hp_if.r_resp = 2'd0;
      hp_if.r_data = 64'hA5A5_0000_0000_0000 | 64'(i); hp_if.r_last = (i == 3);
      exp_d_q.push_back(64'hA5A5_0000_0000_0000 | 64'(i));
      smp();
      checks++; if (up_if.r_valid !== 1'b1) begin errors++; $display("FAIL rd1_r_valid beat=%0d got=%b req=1", i, up_if.r_valid); end
      checks++; begin logic [63:0] e; e = exp_d_q.pop_front(); if (up_if.r_data !== e) begin errors++; $display("FAIL rd1_r_data beat=%0d got=%h req=%h", i, up_if.r_data, e); end end
      checks++; if (up_if.r_last !== (i == 3)) begin errors++; $display("FAIL rd1_r_last beat=%0d got=%b", i, up_if.r_last); end
      checks++; if (rd_outstanding !== 8'd1) begin errors++; $display("FAIL rd1_cnt_hold beat=%0d got=%0d req=1", i, rd_outstanding); end
      step();
    end
    hp_if.r_valid = 1'b0; hp_if.r_last = 1'b0;
    smp();
    checks++; if (rd_outstanding !== 8'd0) begin errors++; $display("FAIL rd1_cnt_down got=%0d req=0", rd_outstanding); end
    step();
  endtask

  task automatic test_read_cap();
    int base;
    base = n_ar_hs;
    for (int i = 0; i < 3; i++) begin
      drive_ar('{addr: 32'hF000_2000 + 32'(i * 64), id: 6'(10 + i), len: 8'd0, size: 3'd3});
      smp();
      checks++; if (up_if.ar_ready !== 1'b1) begin errors++; $display("FAIL cap_up_ready i=%0d got=%b req=1", i, up_if.ar_ready); end
      step();
    end
    up_if.ar_valid = 1'b0;
    repeat (3) begin
      smp();
      checks++; if (hp_if.ar_valid !== 1'b0) begin errors++; $display("FAIL cap_blocked got=%b req=0", hp_if.ar_valid); end
      step();
    end
    smp();
    checks++; if (n_ar_hs - base !== 2) begin errors++; $display("FAIL cap_hs2 got=%0d req=2", n_ar_hs - base); end
    checks++; if (rd_outstanding !== 8'd2) begin errors++; $display("FAIL cap_cnt2 got=%0d req=2", rd_outstanding); end
    step();
    hp_if.r_valid = 1'b1; hp_if.r_last = 1'b1; hp_if.r_id = 6'd10; hp_if.r_resp = 2'd0;
    smp();
    checks++; if (hp_if.ar_valid !== 1'b0) begin errors++; $display("FAIL cap_rlast_cycle got=%b req=0", hp_if.ar_valid); end
    step();
    hp_if.r_valid = 1'b0;
    smp();
    checks++; if (hp_if.ar_valid !== 1'b1) begin errors++; $display("FAIL cap_release got=%b req=1", hp_if.ar_valid); end
    checks++; if (hp_if.ar_addr !== 32'h1000_2080) begin errors++; $display("FAIL cap_third_addr got=%h req=10002080", hp_if.ar_addr); end
    step();
    smp();
    checks++; if (n_ar_hs - base !== 3) begin errors++; $display("FAIL cap_hs3 got=%0d req=3", n_ar_hs - base); end
    step();
    hp_if.r_valid = 1'b1; hp_if.r_last = 1'b1;
    step(); step();
    hp_if.r_valid = 1'b0; hp_if.r_last = 1'b0;
    smp();
    checks++; if (rd_outstanding !== 8'd0) begin errors++; $display("FAIL cap_drain got=%0d req=0", rd_outstanding); end
    step();
  endtask

  task automatic test_w_before_aw();
    up_if.w_valid = 1'b1; up_if.w_data = 64'hD000; up_if.w_last = 1'b0;
    repeat (5) begin
      smp();
      checks++; if ({hp_if.w_valid, up_if.w_ready} !== 2'b00) begin errors++; $display("FAIL wfirst_blocked got=%b req=00", {hp_if.w_valid, up_if.w_ready}); end
      step();
    end
    drive_aw('{addr: 32'h0200_0080, id: 6'd4, len: 8'd3, size: 3'd3});
    step();
    up_if.aw_valid = 1'b0;
    smp();
    checks++; if ({hp_if.aw_valid, hp_if.w_valid} !== 2'b10) begin errors++; $display("FAIL wfirst_aw_cycle got=%b req=10", {hp_if.aw_valid, hp_if.w_valid}); end
    step();
    for (int i = 0; i < 4; i++) begin
      up_if.w_data = 64'hD000 + 64'(i); up_if.w_last = (i == 3);
      exp_d_q.push_back(64'hD000 + 64'(i));
      smp();
      checks++; if ({hp_if.w_valid, up_if.w_ready} !== 2'b11) begin errors++; $display("FAIL wfirst_pass beat=%0d got=%b req=11", i, {hp_if.w_valid, up_if.w_ready}); end
      checks++; begin logic [63:0] e; e = exp_d_q.pop_front(); if (hp_if.w_data !== e) begin errors++; $display("FAIL wfirst_data beat=%0d got=%h req=%h", i, hp_if.w_data, e); end end
      checks++; if (hp_if.w_last !== (i == 3)) begin errors++; $display("FAIL wfirst_last beat=%0d got=%b", i, hp_if.w_last); end
      step();
    end
    up_if.w_data = 64'hBAD; up_if.w_last = 1'b0;
    smp();
    checks++; if (hp_if.w_valid !== 1'b0) begin errors++; $display("FAIL wfirst_credit0 got=%b req=0", hp_if.w_valid); end
    checks++; if (wr_outstanding !== 8'd1) begin errors++; $display("FAIL wfirst_wr1 got=%0d req=1", wr_outstanding); end
    step();
    up_if.w_valid = 1'b0;
    hp_if.b_valid = 1'b1; hp_if.b_id = 6'd4; hp_if.b_resp = 2'd0;
    smp();
    checks++; if ({up_if.b_valid, up_if.b_id} !== {1'b1, 6'd4}) begin errors++; $display("FAIL wfirst_b_pass got=%b", {up_if.b_valid, up_if.b_id}); end
    step();
    hp_if.b_valid = 1'b0;
    smp();
    checks++; if (wr_outstanding !== 8'd0) begin errors++; $display("FAIL wfirst_wr0 got=%0d req=0", wr_outstanding); end
    step();
  endtask

  task automatic test_back_to_back();
    drive_aw('{addr: 32'h0000_0100, id: 6'd1, len: 8'd0, size: 3'd3});
    step();
    up_if.aw_valid = 1'b0;
    step();
    smp();
    checks++; if (wr_outstanding !== 8'd1) begin errors++; $display("FAIL simul_pre got=%0d req=1", wr_outstanding); end
    step();
    drive_aw('{addr: 32'h0000_0200, id: 6'd2, len: 8'd0, size: 3'd3});
    step();
    up_if.aw_valid = 1'b0;
    hp_if.b_valid = 1'b1; hp_if.b_id = 6'd1; hp_if.b_resp = 2'd0;
    smp();
    checks++; if ({hp_if.aw_valid, up_if.b_valid} !== 2'b11) begin errors++; $display("FAIL simul_both got=%b req=11", {hp_if.aw_valid, up_if.b_valid}); end
    step();
    hp_if.b_valid = 1'b0;
    smp();
    checks++; if (wr_outstanding !== 8'd1) begin errors++; $display("FAIL simul_hold got=%0d req=1", wr_outstanding); end
    step();
    hp_if.b_valid = 1'b1; hp_if.b_id = 6'd2;
    step();
    hp_if.b_valid = 1'b0;
    smp();
    checks++; if (wr_outstanding !== 8'd0) begin errors++; $display("FAIL simul_drain got=%0d req=0", wr_outstanding); end
    step();
    up_if.w_valid = 1'b1; up_if.w_last = 1'b1; up_if.w_data = 64'h77;
    for (int i = 0; i < 3; i++) begin
      smp();
      checks++; if (hp_if.w_valid !== (i < 2)) begin errors++; $display("FAIL simul_credit i=%0d got=%b req=%b", i, hp_if.w_valid, (i < 2)); end
      step();
    end
    up_if.w_valid = 1'b0; up_if.w_last = 1'b0;
  endtask

  task automatic test_error_capture();
    drive_aw('{addr: 32'h0000_0300, id: 6'd5, len: 8'd0, size: 3'd3});
    step();
    up_if.aw_valid = 1'b0;
    drive_ar('{addr: 32'h0000_0400, id: 6'd9, len: 8'd0, size: 3'd3});
    step();
    drive_ar('{addr: 32'h0000_0440, id: 6'd10, len: 8'd0, size: 3'd3});
    step();
    up_if.ar_valid = 1'b0;
    repeat (3) step();
    smp();
    checks++; if ({wr_outstanding, rd_outstanding, err_valid} !== {8'd1, 8'd2, 1'b0}) begin errors++; $display("FAIL err_setup got=%h", {wr_outstanding, rd_outstanding, err_valid}); end
    step();
    hp_if.b_valid = 1'b1; hp_if.b_id = 6'd5; hp_if.b_resp = 2'd2;
    step();
    hp_if.b_valid = 1'b0; hp_if.b_resp = 2'd0;
    smp();
    checks++; if ({err_valid, err_is_write, err_id, err_resp} !== {1'b1, 1'b1, 6'd5, 2'd2}) begin errors++; $display("FAIL err_b_capture got=%b req=%b", {err_valid, err_is_write, err_id, err_resp}, {1'b1, 1'b1, 6'd5, 2'd2}); end
    step();
    hp_if.r_valid = 1'b1; hp_if.r_last = 1'b1; hp_if.r_id = 6'd9; hp_if.r_resp = 2'd3;
    step();
    hp_if.r_valid = 1'b0;
    smp();
    checks++; if ({err_valid, err_is_write, err_id, err_resp} !== {1'b1, 1'b1, 6'd5, 2'd2}) begin errors++; $display("FAIL err_sticky got=%b req=%b", {err_valid, err_is_write, err_id, err_resp}, {1'b1, 1'b1, 6'd5, 2'd2}); end
    step();
    hp_if.r_valid = 1'b1; hp_if.r_id = 6'd10; err_clear = 1'b1;
    step();
    hp_if.r_valid = 1'b0; hp_if.r_last = 1'b0; hp_if.r_resp = 2'd0; err_clear = 1'b0;
    smp();
    checks++; if ({err_valid, err_is_write, err_id, err_resp} !== {1'b1, 1'b0, 6'd10, 2'd3}) begin errors++; $display("FAIL err_set_wins got=%b req=%b", {err_valid, err_is_write, err_id, err_resp}, {1'b1, 1'b0, 6'd10, 2'd3}); end
    checks++; if (rd_outstanding !== 8'd0) begin errors++; $display("FAIL err_rd0 got=%0d req=0", rd_outstanding); end
    step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    smp();
    checks++; if ({err_valid, err_resp} !== 3'b000) begin errors++; $display("FAIL err_clear got=%b req=000", {err_valid, err_resp}); end
    step();
    hp_if.b_valid = 1'b1; hp_if.b_id = 6'd7; hp_if.b_resp = 2'd0;
    step();
    hp_if.b_valid = 1'b0;
    smp();
    checks++; if ({err_valid, err_is_write, err_id, err_resp} !== {1'b1, 1'b1, 6'd7, 2'd3}) begin errors++; $display("FAIL err_underflow got=%b req=%b", {err_valid, err_is_write, err_id, err_resp}, {1'b1, 1'b1, 6'd7, 2'd3}); end
    checks++; if (wr_outstanding !== 8'd0) begin errors++; $display("FAIL err_uf_cnt got=%0d req=0", wr_outstanding); end
    step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    drive_ar('{addr: 32'h0000_0600, id: 6'd20, len: 8'd0, size: 3'd3});
    step();
    up_if.ar_valid = 1'b0;
    drive_aw('{addr: 32'h0000_0700, id: 6'd6, len: 8'd3, size: 3'd3});
    step();
    up_if.aw_valid = 1'b0;
    step();
    hp_if.ar_ready = 1'b0;
    drive_ar('{addr: 32'h0000_0800, id: 6'd21, len: 8'd0, size: 3'd3});
    step();
    up_if.ar_valid = 1'b0;
    up_if.w_valid = 1'b1; up_if.w_last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      up_if.w_data = 64'hE0 + 64'(i);
      step();
    end
    up_if.w_data = 64'hE2;
    smp();
    checks++; if ({rd_outstanding, wr_outstanding, hp_if.ar_valid, hp_if.w_valid} !== {8'd1, 8'd1, 2'b11}) begin errors++; $display("FAIL mid_pre got=%h", {rd_outstanding, wr_outstanding, hp_if.ar_valid, hp_if.w_valid}); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({hp_if.ar_valid, hp_if.aw_valid, hp_if.w_valid} !== 3'b000) begin errors++; $display("FAIL mid_valids got=%b req=000", {hp_if.ar_valid, hp_if.aw_valid, hp_if.w_valid}); end
    checks++; if ({rd_outstanding, wr_outstanding} !== 16'd0) begin errors++; $display("FAIL mid_counts got=%h req=0", {rd_outstanding, wr_outstanding}); end
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL mid_err got=%b req=0", err_valid); end
    exp_ar_q.delete();
    exp_aw_q.delete();
    up_if.w_valid = 1'b0;
    hp_if.ar_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    smp();
    checks++; if ({up_if.ar_ready, up_if.aw_ready, hp_if.ar_valid} !== 3'b110) begin errors++; $display("FAIL mid_after got=%b req=110", {up_if.ar_ready, up_if.aw_ready, hp_if.ar_valid}); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    up_if.ar_valid = 0; up_if.ar_addr = 0; up_if.ar_id = 0; up_if.ar_len = 0; up_if.ar_size = 0;
    up_if.aw_valid = 0; up_if.aw_addr = 0; up_if.aw_id = 0; up_if.aw_len = 0; up_if.aw_size = 0;
    up_if.w_valid = 0; up_if.w_data = 0; up_if.w_last = 0;
    up_if.r_ready = 1; up_if.b_ready = 1;
    hp_if.ar_ready = 1; hp_if.aw_ready = 1; hp_if.w_ready = 1;
    hp_if.r_valid = 0; hp_if.r_data = 0; hp_if.r_id = 0; hp_if.r_resp = 0; hp_if.r_last = 0;
    hp_if.b_valid = 0; hp_if.b_id = 0; hp_if.b_resp = 0;

    test_reset();
    test_single_read();
    test_read_cap();
    test_w_before_aw();
    test_back_to_back();
    test_error_capture();
    test_reset_mid_burst();

    checks++; if (exp_ar_q.size() + exp_aw_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d req=0", exp_ar_q.size() + exp_aw_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nasti_hp_adapter.md
Name: nasti_hp_adapter

Overview:
- Sits between the NastiShim slave (memory-master) port and the Zynq S_AXI HP port. Traffic flows upstream (shim) to downstream (HP).
- Remaps addresses into the PS DDR window and buffers AR/AW through skid registers.
- Caps outstanding reads and writes, and holds back W beats until their AW has been issued.
- Records the first error response (SLVERR/DECERR) seen, for host readout.

Parameters:
ADDR_HI, 4'h1, value placed in hp addr[31:28]
REMAP_BITS, 28, low address bits passed through unchanged
MAX_RD, 8, max outstanding read bursts (1..255)
MAX_WR, 8, max outstanding write bursts (1..255)

Ports:
clk  in  1  host clock
reset  in  1  async active-high reset
up_ar_valid/up_ar_ready  in/out  1/1  shim AR handshake
up_ar_addr/id/len/size  in  32/6/8/3  shim AR payload
up_aw_valid/up_aw_ready  in/out  1/1  shim AW handshake
up_aw_addr/id/len/size  in  32/6/8/3  shim AW payload
up_w_valid/up_w_ready  in/out  1/1  shim W handshake
up_w_data/up_w_last  in  64/1  shim W payload
up_r_valid/up_r_ready  out/in  1/1  shim R handshake
up_r_data/id/resp/last  out  64/6/2/1  shim R payload
up_b_valid/up_b_ready  out/in  1/1  shim B handshake
up_b_id/resp  out  6/2  shim B payload
hp_ar_*, hp_aw_*, hp_w_*  out (ready in)  same widths  HP request channels
hp_r_*, hp_b_*  in (ready out)  same widths  HP response channels
rd_outstanding  out  8  current read-burst count
wr_outstanding  out  8  current write-burst count
err_valid  out  1  sticky error flag
err_is_write  out  1  1 = error came from B, 0 = error came from R
err_id/err_resp  out  6/2  id and resp of the captured error
err_clear  in  1  clears the error record

Behaviour:
- Clock `clk`; reset `reset` is asynchronous and active-high.
- Reset values: all counters 0; skids empty; err_* 0; hp_ar_valid and hp_aw_valid 0.
- Ready after reset: up_ar_ready and up_aw_ready are 1 once reset deasserts (skids empty).
- Address remap: hp_addr = {ADDR_HI, addr[REMAP_BITS-1:0]}. id, len and size pass through unchanged.
- AR/AW skid buffers:
  - Each is a 2-entry buffer: full throughput, 1-cycle latency from up handshake to hp valid.
  - up_*_ready = not full. Entries stay in order.
  - hp_*_valid is low while the buffer is empty.
- Read limit:
  - hp_ar_valid = skid nonempty AND rd_cnt < MAX_RD.
  - rd_cnt += 1 on hp AR handshake; rd_cnt -= 1 on hp R handshake with last=1; both in the same cycle leaves it unchanged.
- Write limit: same rule for wr_cnt against MAX_WR. Increments on hp AW handshake, decrements on hp B handshake.
- W credit:
  - w_credit increments on hp AW handshake and decrements on hp W handshake with last=1; both in the same cycle leaves it unchanged.
  - hp_w_valid = up_w_valid AND (w_credit > 0).
  - up_w_ready = hp_w_ready AND (w_credit > 0).
  - W data passes combinationally; it is never forwarded ahead of its AW.
  - w_credit width is 8 bits and saturates at MAX_WR, which wr_cnt already bounds.
- R/B channels: combinational pass-through in both directions, ready included. No reordering.
- Underflow protection: rd_cnt, wr_cnt and w_credit never go below 0. An R-last, B or W-last arriving while the count is 0 leaves it at 0 and sets err_valid with err_resp=2'b11.
- Error capture:
  - On an R or B handshake with resp != 0 while err_valid=0, latch id, resp and is_write, and set err_valid.
  - Later errors are ignored until cleared.
  - err_clear and a new error in the same cycle: the new error is captured (set wins).
  - If R and B both error in the same cycle, B wins.
- Reset mid-operation: all state is discarded immediately and in-flight bursts are abandoned. The HP side must be reset in the same window.
- rd_outstanding and wr_outstanding are the registered counts, zero-extended to 8 bits.

Decomposition:
- Shared package nasti_hp_pkg holds:
  - width constants: ADDR_W=32, ID_W=6, LEN_W=8, SIZE_W=3, DATA_W=64, RESP_W=2;
  - resp encodings: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3;
  - a packed struct for the AR/AW payload.
- One sub-module, nasti_skid_buf, parameterised on payload width; instantiated twice (AR, AW).

Test Plan:
- Single read: up AR addr=0x0000_1040, len=3 → hp AR addr=0x1000_1040 one cycle later; 4 R beats pass through; rd_outstanding goes 1 then back to 0 after last.
- Read cap: MAX_RD=2, 3 back-to-back ARs, hp_r held idle → only 2 hp AR handshakes; the third is issued the cycle after the first R-last handshake.
- W before AW: up W beats valid 5 cycles before up AW → hp_w_valid stays 0 until the AW hp handshake. Then all 4 beats pass; w_credit ends at 0.
- Simultaneous events: AW handshake and B handshake in the same cycle with wr_cnt=1 → wr_cnt stays 1.
- Error capture: B resp=2 id=5, then R resp=3 → err_valid=1, err_is_write=1, err_id=5, err_resp=2. Then err_clear together with the R error → err_is_write=0, err_resp=3.
- Reset mid-burst: assert reset after 2 of 4 W beats → all valid outputs 0 and counters 0 asynchronously; after release up_ar_ready=1.
